prng_ctrl: RTL and testbench

PRNG_CTRL -- requirements
Module: prng_ctrl

---
 rtl/prng_pkg.sv | 6 +
 rtl/prng_dly_cnt.sv | 22 ++
 rtl/prng_ctrl.sv | 104 ++++++++++
 tb/tb_prng_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// prng_pkg: shared FSM state encoding, operation encodings and result offset for prng_ctrl.
package prng_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_SEED, ST_RUN, ST_CAP, ST_WB} state_e;
   typedef enum logic [1:0] {OP_SEED = 2'd0, OP_GEN = 2'd1} op_e;
   localparam int unsigned PRNG_RES_OFS = 7287;
endpackage

// File: rtl/prng_dly_cnt.sv
// prng_dly_cnt: PRNG step down-counter; loads the step count, decrements once per step.
//   clk, reset_b : clock, async active-low reset
//   load_i/val_i : load val_i into the counter
//   dec_i        : decrement by one
//   last_o       : counter is at 1, i.e. the current step is the final one
module prng_dly_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset_b,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] val_i,
   output logic         last_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? val_i : dec_i ? cnt_q - W'(1) : cnt_q;
   always_ff @(posedge clk or negedge reset_b)
      if (!reset_b) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   assign last_o = cnt_q == W'(1);
endmodule

// File: rtl/prng_ctrl.sv
// prng_ctrl: sequences PRNG seed/step operations and writes the offset result to the GPRF.
//   clk, reset_b                    : clock, async active-low reset
//   t_cs, req_rdy, req_typ/imm/dly  : request handshake (0=SEED, 1=GEN, others illegal)
//   prng_en, prng_t_sel, prng_t_dat : PRNG control (load seed when t_sel=1, else step)
//   prng_dat                        : current PRNG output
//   gprf_wr_vld/dat/ack             : result write-back handshake
//   busy, err                       : not idle; one-cycle illegal-request pulse
module prng_ctrl
   import prng_pkg::*;
#(
   parameter int unsigned PRNG_DAT_W = 16,
   parameter int unsigned DLY_W      = 8,
   parameter int unsigned PRNG_TYP_W = 2,
   parameter int unsigned RES_OFS    = PRNG_RES_OFS
) (
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  t_cs,
   output logic                  req_rdy,
   input  logic [PRNG_TYP_W-1:0] req_typ,
   input  logic [PRNG_DAT_W-1:0] req_imm,
   input  logic [DLY_W-1:0]      req_dly,
   output logic                  prng_en,
   output logic                  prng_t_sel,
   output logic [PRNG_DAT_W-1:0] prng_t_dat,
   input  logic [PRNG_DAT_W-1:0] prng_dat,
   output logic                  gprf_wr_vld,
   output logic [PRNG_DAT_W-1:0] gprf_wr_dat,
   input  logic                  gprf_wr_ack,
   output logic                  busy,
   output logic                  err
);
   state_e                  state_q;
   logic                    en_q, sel_q, vld_q, err_q, last;
   logic [PRNG_DAT_W-1:0]   seed_q, wr_dat_q;
   logic                    accept, is_seed, is_gen;

   assign accept  = t_cs && state_q == ST_IDLE;
   assign is_seed = req_typ == PRNG_TYP_W'(OP_SEED);
   assign is_gen  = req_typ == PRNG_TYP_W'(OP_GEN);

   prng_dly_cnt #(.W(DLY_W)) u_cnt (
      .clk     (clk),
      .reset_b (reset_b),
      .load_i  (accept && is_gen),
      .dec_i   (state_q == ST_RUN),
      .val_i   (req_dly),
      .last_o  (last)
   );

   // Outputs are registered, so prng_en is set on the edge that enters the stepping cycle.
   always_ff @(posedge clk or negedge reset_b)
      if (!reset_b) begin
         state_q  <= ST_IDLE;
         en_q     <= 1'b0;
         sel_q    <= 1'b0;
         seed_q   <= '0;
         vld_q    <= 1'b0;
         wr_dat_q <= '0;
         err_q    <= 1'b0;
      end else begin
         en_q  <= 1'b0;
         sel_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE:
               if (accept) begin
                  if (is_seed) begin
                     state_q <= ST_SEED;
                     en_q    <= 1'b1;
                     sel_q   <= 1'b1;
                     seed_q  <= req_imm;
                  end else if (is_gen) begin
                     state_q <= req_dly != '0 ? ST_RUN : ST_CAP;
                     en_q    <= req_dly != '0;
                  end else err_q <= 1'b1;
               end
            ST_SEED: state_q <= ST_IDLE;
            ST_RUN:
               if (last) state_q <= ST_CAP;
               else      en_q    <= 1'b1;
            ST_CAP: begin
               wr_dat_q <= prng_dat + PRNG_DAT_W'(RES_OFS);
               vld_q    <= 1'b1;
               state_q  <= ST_WB;
            end
            ST_WB:
               if (gprf_wr_ack) begin
                  vld_q   <= 1'b0;
                  state_q <= ST_IDLE;
               end
            default: state_q <= ST_IDLE;
         endcase
      end

   assign req_rdy     = state_q == ST_IDLE;
   assign busy        = state_q != ST_IDLE;
   assign prng_en     = en_q;
   assign prng_t_sel  = sel_q;
   assign prng_t_dat  = seed_q;
   assign gprf_wr_vld = vld_q;
   assign gprf_wr_dat = wr_dat_q;
   assign err         = err_q;
endmodule

// File: tb/tb_prng_ctrl.sv
// tb_prng_ctrl: directed self-checking bench for prng_ctrl with a 16-bit Galois LFSR stand-in.
module tb_prng_ctrl;
   logic        clk = 1'b0;
   logic        reset_b = 1'b0;
   logic        t_cs = 1'b0;
   logic        req_rdy;
   logic [1:0]  req_typ = 2'd0;
   logic [15:0] req_imm = 16'h0;
   logic [7:0]  req_dly = 8'h0;
   logic        prng_en, prng_t_sel;
   logic [15:0] prng_t_dat;
   logic [15:0] prng_dat = 16'h0;
   logic        gprf_wr_vld;
   logic [15:0] gprf_wr_dat;
   logic        gprf_wr_ack = 1'b0;
   logic        busy, err;
   int          n_chk = 0;
   int          n_fail = 0;

   prng_ctrl dut (
      .clk         (clk),
      .reset_b     (reset_b),
      .t_cs        (t_cs),
      .req_rdy     (req_rdy),
      .req_typ     (req_typ),
      .req_imm     (req_imm),
      .req_dly     (req_dly),
      .prng_en     (prng_en),
      .prng_t_sel  (prng_t_sel),
      .prng_t_dat  (prng_t_dat),
      .prng_dat    (prng_dat),
      .gprf_wr_vld (gprf_wr_vld),
      .gprf_wr_dat (gprf_wr_dat),
      .gprf_wr_ack (gprf_wr_ack),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   // PRNG stand-in: load seed or take one Galois LFSR step (taps 0xB400) when enabled.
   always @(posedge clk)
      if (prng_en) prng_dat <= prng_t_sel ? prng_t_dat : (prng_dat >> 1) ^ (prng_dat[0] ? 16'hB400 : 16'h0);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic seed(input logic [15:0] imm);
      t_cs = 1'b1; req_typ = 2'd0; req_imm = imm;
      tick;
      t_cs = 1'b0;
      check("seed_en", {29'd0, prng_en, prng_t_sel, busy}, 32'b111);
      check("seed_dat", 32'(prng_t_dat), 32'(imm));
      tick;
      check("seed_done", {30'd0, prng_en, req_rdy}, 32'b01);
   endtask

   // Issue GEN and wait (bounded) for vld; checks step count, latency and data.
   task automatic gen(input logic [7:0] dly, input logic [15:0] exp_dat);
      int en_n = 0;
      int vld_at = -1;
      t_cs = 1'b1; req_typ = 2'd1; req_dly = dly;
      tick;
      t_cs = 1'b0;
      for (int c = 1; c <= int'(dly) + 10 && vld_at < 0; c++) begin
         if (prng_en) en_n++;
         if (gprf_wr_vld) vld_at = c;
         else tick;
      end
      check("gen_steps", 32'(en_n), 32'(dly));
      check("gen_latency", 32'(vld_at), 32'(dly) + 32'd2);
      check("gen_data", 32'(gprf_wr_dat), 32'(exp_dat));
   endtask

   task automatic ack;
      gprf_wr_ack = 1'b1;
      tick;
      gprf_wr_ack = 1'b0;
      check("ack_idle", {30'd0, gprf_wr_vld, req_rdy}, 32'b01);
   endtask

   initial begin
      tick;
      check("rst_ctl", {26'd0, req_rdy, busy, prng_en, prng_t_sel, gprf_wr_vld, err}, 32'b100000);
      check("rst_dat", {prng_t_dat, gprf_wr_dat}, 32'd0);
      reset_b = 1'b1;
      tick;
      gprf_wr_ack = 1'b1;
      tick;
      gprf_wr_ack = 1'b0;
      check("ack_outside_wb", {30'd0, gprf_wr_vld, req_rdy}, 32'b01);

      seed(16'h1234);
      check("seed_hold", 32'(prng_t_dat), 32'h1234);
      gen(8'd3, 16'hD2BD);

      // Backpressure: hold ack low, pulse seed requests that must be ignored.
      for (int i = 0; i < 5; i++) begin
         t_cs = 1'b1; req_typ = 2'd0; req_imm = 16'hAAAA;
         tick;
         check("bp_stable", {15'd0, gprf_wr_vld, gprf_wr_dat}, {15'd0, 1'b1, 16'hD2BD});
         check("bp_ignore", {29'd0, prng_en, req_rdy, busy}, 32'b001);
      end
      t_cs = 1'b0;
      check("bp_seed_kept", 32'(prng_t_dat), 32'h1234);
      ack;

      seed(16'hFFFF);
      gen(8'd0, 16'h1C76);
      ack;
      gen(8'd1, 16'hE876);
      ack;

      t_cs = 1'b1; req_typ = 2'd2;
      tick;
      t_cs = 1'b0;
      check("illegal_err", {28'd0, err, req_rdy, prng_en, busy}, 32'b1100);
      tick;
      check("illegal_pulse", {30'd0, err, req_rdy}, 32'b01);

      // Reset in the middle of a 10-step GEN.
      t_cs = 1'b1; req_typ = 2'd1; req_dly = 8'd10;
      tick;
      t_cs = 1'b0;
      tick; tick; tick;
      check("run_cyc4", {30'd0, prng_en, busy}, 32'b11);
      reset_b = 1'b0;
      #1;
      check("async_rst", {26'd0, req_rdy, busy, prng_en, prng_t_sel, gprf_wr_vld, err}, 32'b100000);
      check("async_rst_dat", {prng_t_dat, gprf_wr_dat}, 32'd0);
      tick;
      reset_b = 1'b1;
      begin
         int vld_seen = 0;
         for (int i = 0; i < 15; i++) begin
            if (gprf_wr_vld || busy) vld_seen++;
            tick;
         end
         check("no_vld_after_rst", 32'(vld_seen), 32'd0);
      end
      seed(16'h5A5A);
      gen(8'd2, 16'hBF0D);
      ack;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
